detect_frame_counter: RTL and testbench
=======================================

# detect_frame_counter

Downstream consumer of the dual-sequence detector's Mealy output `y`. It counts detection pulses over fixed-length frames of qualified serial bits and presents each frame's hit count to a host over a valid/ready handshake. It also flags saturation and overrun. It sits between the detector and the status/telemetry logic, in the same clock domain as the detector.

## Interface
- `FRAME_LEN`, default 16: qualified bits per frame, legal range 2..65535.
- `CNT_W`, default 8: width of the hit count; the count saturates at 2^CNT_W−1.

Ports (all 1 bit unless noted):
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high; clears all state on the next rising edge.
- `bit_en`  in  1  qualifies the cycle: one serial bit was presented to the detector.
- `y_in`  in  1  detector output `y`; sampled only when `bit_en`=1.
- `cnt_ready`  in  1  consumer accepts `cnt_data`.
- `cnt_valid`  out  1  `cnt_data` holds a completed frame result.
- `cnt_data`  out  CNT_W  hits in the completed frame.
- `cnt_sat`  out  1  the completed frame saturated.
- `overrun`  out  1  sticky: a frame result was dropped.
- `clr_ovr`  in  1  clears `overrun`.

## Operation
- Frame position counter `pos`, range 0..FRAME_LEN−1, increments on each `bit_en` cycle and wraps to 0 after FRAME_LEN−1.
- Running counter `hits`, CNT_W bits, plus a sticky `sat_r`.
  - On a `bit_en` cycle with `y_in`=1: `hits` increments, saturating.
  - Attempting to increment past the maximum sets `sat_r`.
- Frame close: a `bit_en` cycle with `pos`=FRAME_LEN−1.
  - Final count is `hits` + `y_in`, saturated. The close-cycle hit is included.
  - `hits`, `sat_r` and `pos` return to 0 on the same edge.
- Output holding register, two-state FSM:
  - EMPTY, with `cnt_valid`=0.
  - FULL, with `cnt_valid`=1.
- Transitions:
  - EMPTY, frame close → FULL; load result.
  - FULL, `cnt_ready`=1, no close → EMPTY.
  - FULL, `cnt_ready`=1, close → FULL; load new result. Back-to-back transfer, no drop.
  - FULL, `cnt_ready`=0, close → FULL; held data unchanged; new result dropped; `overrun` set.
- `cnt_data` and `cnt_sat` remain stable while FULL and `cnt_ready`=0.
- `clr_ovr` clears `overrun`. If `clr_ovr` and a new overrun occur in the same cycle, set wins.
- `bit_en`=0: no state change in the counter path; `y_in` is ignored.

## Timing
- Reset values: `cnt_valid`=0, `cnt_data`=0, `cnt_sat`=0, `overrun`=0, `pos`=0, `hits`=0, FSM=EMPTY.
- Latency: `cnt_valid` rises on the clk edge that samples the closing `bit_en` cycle. Data is visible on the following cycle.
- Handshake: a transfer occurs on an edge where `cnt_valid`=1 and `cnt_ready`=1. `cnt_ready` may be high while EMPTY; it has no effect then.
- Reset mid-frame discards the partial count and the held result. The next frame starts at `pos`=0 with the first `bit_en` after reset deasserts.
- `reset` overrides every other input in the same cycle.
- All outputs are registered; there is no combinational input-to-output path.

## Configuration
- `DETECT_FRAME_PEAK_EN`
- Defined:
  - Adds output `peak_cnt` [CNT_W−1:0]: the maximum saturated frame count closed since reset, reset value 0.
  - It updates on every frame close, including dropped frames.
  - `clr_ovr` also clears `peak_cnt` to 0.
- Undefined: the port and the peak logic are absent. All other behaviour is identical.

## Test plan
- Reset, FRAME_LEN=4, `cnt_ready`=1, `bit_en`=1 every cycle, `y_in`=1,0,0,1 → one cycle after the 4th bit `cnt_valid`=1 with `cnt_data`=2 and `cnt_sat`=0. `cnt_valid`=0 the cycle after.
- FRAME_LEN=8, CNT_W=2, `y_in`=1 on all 8 bits → `cnt_data`=3, `cnt_sat`=1. The next frame with `y_in`=0 throughout → `cnt_data`=0, `cnt_sat`=0.
- `bit_en` toggling 1,0,1,0 with `y_in`=1 on disabled cycles only → frame closes after FRAME_LEN enabled bits with `cnt_data`=0.
- `cnt_ready`=0 across two frame closes with counts 1 then 3 → `cnt_data` stays 1 and `overrun`=1.
  - Then `cnt_ready`=1 → one transfer, `cnt_valid` drops.
  - Then `clr_ovr` pulse → `overrun`=0.
- Held result with `cnt_ready`=1 on the same edge as a frame close with count 2 → no overrun; `cnt_valid` stays 1 and `cnt_data`=2.
- `reset` after 3 of 4 bits with 2 hits, then 4 bits with 1 hit → `cnt_data`=1. With `DETECT_FRAME_PEAK_EN` defined, `peak_cnt` tracks 2,1,3 as 2,2,3.

Source files
------------

// File: rtl/detect_frame_counter.sv
// detect_frame_counter: counts detector hits per frame of qualified bits
// and hands each frame count to a host over a valid/ready holding register.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset
//   bit_en     in   qualifies one serial bit
//   y_in       in   detector pulse, sampled when bit_en=1
//   cnt_ready  in   host accepts cnt_data
//   clr_ovr    in   clears overrun (and peak_cnt when enabled)
//   cnt_valid  out  holding register contains a frame result
//   cnt_data   out  saturated hit count of the held frame
//   cnt_sat    out  held frame saturated
//   overrun    out  sticky, a frame result was dropped
//   peak_cnt   out  max frame count since reset (DETECT_FRAME_PEAK_EN only)
//
// Optional feature macro: DETECT_FRAME_PEAK_EN
module detect_frame_counter #(
    parameter int FRAME_LEN = 16,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_en,
    input  logic             y_in,
    input  logic             cnt_ready,
    input  logic             clr_ovr,
    output logic             cnt_valid,
    output logic [CNT_W-1:0] cnt_data,
    output logic             cnt_sat,
    output logic             overrun
`ifdef DETECT_FRAME_PEAK_EN
    ,
    output logic [CNT_W-1:0] peak_cnt
`endif
);

    localparam int POS_W = $clog2(FRAME_LEN);
    localparam logic [POS_W-1:0] LAST = POS_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] MAXV = '1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           r_state;
    logic [POS_W-1:0] r_pos;
    logic [CNT_W-1:0] r_hits;
    logic             r_sat;
    logic [CNT_W-1:0] r_data;
    logic             r_data_sat;
    logic             r_ovr;

    logic             w_close;
    logic             w_at_max;
    logic [CNT_W-1:0] w_final;
    logic             w_final_sat;

    assign w_close  = bit_en && (r_pos == LAST);
    assign w_at_max = (r_hits == MAXV);

    // Close-cycle hit is folded into the frame result, saturating.
    assign w_final     = (y_in && !w_at_max) ? r_hits + CNT_W'(1) : r_hits;
    assign w_final_sat = r_sat || (y_in && w_at_max);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pos  <= '0;
            r_hits <= '0;
            r_sat  <= 1'b0;
        end else if (bit_en) begin
            if (w_close) begin
                r_pos  <= '0;
                r_hits <= '0;
                r_sat  <= 1'b0;
            end else begin
                r_pos <= r_pos + POS_W'(1);
                if (y_in) begin
                    if (w_at_max) r_sat <= 1'b1;
                    else          r_hits <= r_hits + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= EMPTY;
            r_data     <= '0;
            r_data_sat <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            // Clear first so a same-cycle overrun set takes priority.
            if (clr_ovr) r_ovr <= 1'b0;
            unique case (r_state)
                EMPTY: begin
                    if (w_close) begin
                        r_state    <= FULL;
                        r_data     <= w_final;
                        r_data_sat <= w_final_sat;
                    end
                end
                FULL: begin
                    if (w_close) begin
                        if (cnt_ready) begin
                            r_data     <= w_final;
                            r_data_sat <= w_final_sat;
                        end else begin
                            r_ovr <= 1'b1;
                        end
                    end else if (cnt_ready) begin
                        r_state <= EMPTY;
                    end
                end
            endcase
        end
    end

    assign cnt_valid = (r_state == FULL);
    assign cnt_data  = r_data;
    assign cnt_sat   = r_data_sat;
    assign overrun   = r_ovr;

`ifdef DETECT_FRAME_PEAK_EN
    logic [CNT_W-1:0] r_peak;

    // Tracks every close, dropped or not; a close wins over clr_ovr.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_peak <= '0;
        end else if (w_close) begin
            if (clr_ovr || (w_final > r_peak)) r_peak <= w_final;
        end else if (clr_ovr) begin
            r_peak <= '0;
        end
    end

    assign peak_cnt = r_peak;
`endif

endmodule

// File: tb/tb_detect_frame_counter.sv
// Self-checking bench for detect_frame_counter (FRAME_LEN=4, CNT_W=2)
// with an integer-level frame model and random stimulus.
module tb_detect_frame_counter;

    localparam int FL   = 4;
    localparam int CW   = 2;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          bit_en = 1'b0;
    logic          y_in = 1'b0;
    logic          cnt_ready = 1'b0;
    logic          clr_ovr = 1'b0;
    logic          cnt_valid;
    logic [CW-1:0] cnt_data;
    logic          cnt_sat;
    logic          overrun;
`ifdef DETECT_FRAME_PEAK_EN
    logic [CW-1:0] peak_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: unbounded raw hit count, saturation applied at close.
    int m_nbits = 0;
    int m_raw   = 0;
    bit m_valid = 0;
    int m_data  = 0;
    bit m_sat   = 0;
    bit m_ovr   = 0;
    int m_peak  = 0;
    bit started = 0;

    detect_frame_counter #(
        .FRAME_LEN(FL),
        .CNT_W    (CW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bit_en   (bit_en),
        .y_in     (y_in),
        .cnt_ready(cnt_ready),
        .clr_ovr  (clr_ovr),
        .cnt_valid(cnt_valid),
        .cnt_data (cnt_data),
        .cnt_sat  (cnt_sat),
        .overrun  (overrun)
`ifdef DETECT_FRAME_PEAK_EN
        ,
        .peak_cnt (peak_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit close;
        int fc;
        bit fs;
        close = 0;
        fc = 0;
        fs = 0;
        if (reset) begin
            m_nbits = 0; m_raw = 0; m_valid = 0; m_data = 0;
            m_sat = 0; m_ovr = 0; m_peak = 0; started = 1;
            return;
        end
        if (bit_en) begin
            m_raw += int'(y_in);
            m_nbits++;
            if (m_nbits == FL) begin
                close = 1;
                fc = (m_raw > MAXC) ? MAXC : m_raw;
                fs = (m_raw > MAXC);
                m_nbits = 0;
                m_raw = 0;
            end
        end
        if (clr_ovr) begin
            m_ovr = 0;
            m_peak = 0;
        end
        if (close && fc > m_peak) m_peak = fc;
        if (m_valid && cnt_ready) m_valid = 0;
        if (close) begin
            if (!m_valid) begin
                m_valid = 1;
                m_data = fc;
                m_sat = fs;
            end else begin
                m_ovr = 1;
            end
        end
    endtask

    // Drive one cycle, advance model at the edge, return at negedge.
    task automatic cyc(input bit be, input bit y, input bit rdy,
                       input bit clr = 0, input bit rst = 0);
        bit_en = be;
        y_in = y;
        cnt_ready = rdy;
        clr_ovr = clr;
        reset = rst;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic frame4(input logic [3:0] ys, input bit rdy);
        for (int i = 3; i >= 0; i--) begin
            logic [3:0] v;
            v = ys;
            cyc(1, v[i], rdy);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("valid", int'(cnt_valid), int'(m_valid));
            chk("overrun", int'(overrun), int'(m_ovr));
            if (m_valid) begin
                chk("data", int'(cnt_data), m_data);
                chk("sat", int'(cnt_sat), int'(m_sat));
            end
`ifdef DETECT_FRAME_PEAK_EN
            chk("peak", int'(peak_cnt), m_peak);
`endif
        end
    end

    initial begin
        cyc(0, 0, 0, 0, 1);
        chk("rst_valid", int'(cnt_valid), 0);
        chk("rst_data", int'(cnt_data), 0);
        chk("rst_sat", int'(cnt_sat), 0);
        chk("rst_ovr", int'(overrun), 0);

        frame4(4'b1001, 1);
        chk("f1_valid", int'(cnt_valid), 1);
        chk("f1_data", int'(cnt_data), 2);
        chk("f1_sat", int'(cnt_sat), 0);
        cyc(0, 0, 1);
        chk("f1_drop", int'(cnt_valid), 0);

        frame4(4'b1111, 1);
        chk("sat_data", int'(cnt_data), 3);
        chk("sat_flag", int'(cnt_sat), 1);
        frame4(4'b0000, 1);
        chk("zero_data", int'(cnt_data), 0);
        chk("zero_sat", int'(cnt_sat), 0);
        cyc(0, 0, 1);

        for (int i = 0; i < 7; i++) cyc(~i[0], i[0], 1);
        chk("gap_valid", int'(cnt_valid), 1);
        chk("gap_data", int'(cnt_data), 0);
        cyc(0, 1, 1);

        frame4(4'b1000, 0);
        frame4(4'b1110, 0);
        chk("ovr_data", int'(cnt_data), 1);
        chk("ovr_flag", int'(overrun), 1);
        cyc(0, 0, 1);
        chk("ovr_xfer", int'(cnt_valid), 0);
        cyc(0, 0, 0, 1);
        chk("ovr_clr", int'(overrun), 0);

        frame4(4'b0100, 0);
        cyc(1, 1, 0);
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        cyc(1, 1, 1);
        chk("b2b_valid", int'(cnt_valid), 1);
        chk("b2b_data", int'(cnt_data), 2);
        chk("b2b_ovr", int'(overrun), 0);
        cyc(0, 0, 1);

        cyc(1, 1, 1);
        cyc(1, 1, 1);
        cyc(1, 0, 1);
        cyc(0, 0, 1, 0, 1);
        frame4(4'b0010, 1);
        chk("rst_mid_data", int'(cnt_data), 1);
        frame4(4'b1100, 1);
        frame4(4'b0001, 1);
        frame4(4'b1011, 1);
        chk("after_data", int'(cnt_data), 3);
`ifdef DETECT_FRAME_PEAK_EN
        chk("peak_lit", int'(peak_cnt), 3);
`endif
        cyc(0, 0, 1);

        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0,
                $urandom_range(0, 99) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
